// File: rtl/code_block_loader_pkg.sv
// ----------------------------------------------------------------------------
// code_block_loader_pkg
//   Shared coder constants and the block FSM state type. The state type is
//   also used by the downstream serializer, so its encoding must stay stable.
// ----------------------------------------------------------------------------
package code_block_loader_pkg;

    localparam int K_MAX       = 6144;  // large code block size, buffer width
    localparam int K_SMALL     = 1056;  // small code block size
    localparam int W           = 8;     // input byte width
    localparam int BYTES_MAX   = K_MAX / W;    // 768
    localparam int BYTES_SMALL = K_SMALL / W;  // 132

    // Byte counter width (covers 0..767) and bit-offset width (covers 0..6143).
    localparam int CNT_W = 10;
    localparam int OFS_W = $clog2(K_MAX);

    localparam logic [CNT_W-1:0] LAST_MAX   = CNT_W'(BYTES_MAX - 1);
    localparam logic [CNT_W-1:0] LAST_SMALL = CNT_W'(BYTES_SMALL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } blk_state_e;

endpackage : code_block_loader_pkg

// File: rtl/code_block_loader.sv
// ----------------------------------------------------------------------------
// code_block_loader
//   Collects one turbo code block (6144 or 1056 bits) from a byte stream and
//   presents it as a flat, frozen 6144-bit block for the interleaver.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle pulse: begin (or restart) a block
//   k_sel           block size, sampled on start (1 = 6144, 0 = 1056)
//   in_data/valid/ready   byte input stream
//   blk_data        assembled block, byte 0 bit 0 at blk_data[0]
//   blk_k_eq_6144   latched k_sel for the block in blk_data
//   blk_valid/ready block output handshake
//   busy            high while filling or holding a block
//
// Handshakes: a beat moves when valid and ready are both high at a rising
// edge. ready/valid driven by this block depend on FSM state only, never
// combinationally on the partner's signal.
// ----------------------------------------------------------------------------
module code_block_loader
    import code_block_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             k_sel,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [K_MAX-1:0] blk_data,
    output logic             blk_k_eq_6144,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             busy
);

    blk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [K_MAX-1:0] blk_data_q;
    logic             k_q;

    logic             clear;      // new block: relatch k_sel, wipe buffer
    logic             write;      // byte transfer this cycle
    logic             last_byte;  // counter points at the final byte
    logic [OFS_W-1:0] wr_base;

    assign last_byte = (cnt_q == (k_q ? LAST_MAX : LAST_SMALL));
    assign wr_base   = OFS_W'(cnt_q) * OFS_W'(W);

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        write   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (start) begin
                    // Restart wins over a byte offered in the same cycle.
                    clear   = 1'b1;
                    state_d = FILL;
                end else if (in_valid) begin
                    write = 1'b1;
                    if (last_byte) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    if (start) begin
                        clear   = 1'b1;
                        state_d = FILL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from state only
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            HOLD: begin
                blk_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
            end
        endcase
    end

    assign blk_data      = blk_data_q;
    assign blk_k_eq_6144 = k_q;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Block buffer, size select and byte counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_data_q <= '0;
            k_q        <= 1'b0;
            cnt_q      <= '0;
        end else if (clear) begin
            // Clearing the whole buffer keeps the unused upper bits of a
            // small block at zero without any extra masking on the output.
            blk_data_q <= '0;
            k_q        <= k_sel;
            cnt_q      <= '0;
        end else if (write) begin
            blk_data_q[wr_base +: W] <= in_data;
            cnt_q                    <= last_byte ? '0 : cnt_q + 1'b1;
        end
    end

endmodule : code_block_loader

// File: tb/tb_code_block_loader.sv
// ----------------------------------------------------------------------------
// tb_code_block_loader
//   Directed bench for code_block_loader. Bytes accepted by the loader are
//   recorded in an expected queue; a block is rebuilt from that queue and
//   compared word by word against blk_data.
// ----------------------------------------------------------------------------
module tb_code_block_loader;
    import code_block_loader_pkg::*;

    // ------------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             k_sel = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [K_MAX-1:0] blk_data;
    logic             blk_k_eq_6144;
    logic             blk_valid;
    logic             blk_ready = 1'b0;
    logic             busy;

    always #5 clk = ~clk;

    code_block_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .k_sel         (k_sel),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .blk_data      (blk_data),
        .blk_k_eq_6144 (blk_k_eq_6144),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .busy          (busy)
    );

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    int               checks = 0;
    int               errors = 0;
    logic [W-1:0]     exp_q[$];
    logic [K_MAX-1:0] exp_blk;
    int               sent;
    int               cycles;
    bit               valid_early;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare blk_data against exp_blk, reporting the number of bad 32-bit words.
    task automatic compare_blk(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < K_MAX / 32; i++) begin
            if (blk_data[i*32 +: 32] !== exp_blk[i*32 +: 32]) nbad++;
        end
        check(tag, 32'(nbad), 32'd0);
    endtask

    // Rebuild the expected block from the byte queue and compare.
    task automatic check_block(input string tag, input int n);
        check({tag, "_qsize"}, 32'(exp_q.size()), 32'(n));
        exp_blk = '0;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) exp_blk[i*W +: W] = exp_q.pop_front();
        end
        exp_q.delete();
        compare_blk(tag);
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; optionally offer a byte in the same cycle.
    task automatic do_start(input logic k, input logic with_byte);
        start    = 1'b1;
        k_sel    = k;
        in_valid = with_byte;
        in_data  = 8'hEE;
        exp_q.delete();
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        k_sel    = ~k;  // later changes must not matter
    endtask

    // Send n bytes. mode 0: byte index, 1: constant val, 2: random.
    // With gaps, in_valid is low every third cycle.
    task automatic send_bytes(input int n, input int mode, input logic [W-1:0] val, input bit gaps);
        sent        = 0;
        cycles      = 0;
        valid_early = 1'b0;
        while (sent < n && cycles < 3 * n + 20) begin
            if (gaps && (cycles % 3 == 2)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                case (mode)
                    0:       in_data = W'(sent);
                    1:       in_data = val;
                    default: in_data = W'($urandom_range(0, 255));
                endcase
            end
            if (blk_valid) valid_early = 1'b1;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int seen_rdy;
        int seen_drop;

        // Reset values
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_blk_valid", 32'(blk_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_k", 32'(blk_k_eq_6144), 32'd0);
        check("rst_data_zero", 32'(|blk_data), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1: small block, byte index data, full rate
        do_start(1'b0, 1'b0);
        check("t1_fill_ready", 32'(in_ready), 32'd1);
        send_bytes(132, 0, 8'h00, 1'b0);
        check("t1_xfers", 32'(sent), 32'd132);
        check("t1_cycles", 32'(cycles), 32'd132);
        check("t1_early_valid", 32'(valid_early), 32'd0);
        check("t1_blk_valid", 32'(blk_valid), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_byte0", 32'(blk_data[7:0]), 32'h00);
        check("t1_byte131", 32'(blk_data[1055:1048]), 32'h83);
        check("t1_upper_zero", 32'(|blk_data[K_MAX-1:K_SMALL]), 32'd0);
        check("t1_k", 32'(blk_k_eq_6144), 32'd0);
        check_block("t1_block", 132);
        consume();
        check("t1_drop_valid", 32'(blk_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_ready", 32'(in_ready), 32'd0);

        // 2: large block of 0xA5 with a gap every third cycle
        do_start(1'b1, 1'b0);
        send_bytes(768, 1, 8'hA5, 1'b1);
        check("t2_xfers", 32'(sent), 32'd768);
        check("t2_early_valid", 32'(valid_early), 32'd0);
        check("t2_blk_valid", 32'(blk_valid), 32'd1);
        check("t2_k", 32'(blk_k_eq_6144), 32'd1);
        check_block("t2_block", 768);

        // 3: hold for 50 cycles with stray input traffic
        seen_rdy  = 0;
        seen_drop = 0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) seen_rdy++;
            if (!blk_valid) seen_drop++;
            step();
        end
        in_valid = 1'b0;
        check("t3_ready_seen", 32'(seen_rdy), 32'd0);
        check("t3_valid_drop", 32'(seen_drop), 32'd0);
        check("t3_k", 32'(blk_k_eq_6144), 32'd1);
        compare_blk("t3_block_frozen");
        consume();
        check("t3_drop_valid", 32'(blk_valid), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd0);

        // 4: abort a large fill, restart small; byte on the start cycle is dropped
        do_start(1'b1, 1'b0);
        send_bytes(100, 1, 8'hFF, 1'b0);
        check("t4_partial_xfers", 32'(sent), 32'd100);
        do_start(1'b0, 1'b1);
        check("t4_restart_ready", 32'(in_ready), 32'd1);
        check("t4_restart_clear", 32'(|blk_data), 32'd0);
        send_bytes(132, 1, 8'h01, 1'b0);
        check("t4_xfers", 32'(sent), 32'd132);
        check("t4_blk_valid", 32'(blk_valid), 32'd1);
        check("t4_k", 32'(blk_k_eq_6144), 32'd0);
        check("t4_upper_zero", 32'(|blk_data[K_MAX-1:K_SMALL]), 32'd0);
        check_block("t4_block", 132);
        consume();

        // 5: asynchronous reset mid-fill
        do_start(1'b1, 1'b0);
        send_bytes(400, 1, 8'h5A, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h11;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(in_ready), 32'd0);
        check("t5_rst_valid", 32'(blk_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_k", 32'(blk_k_eq_6144), 32'd0);
        check("t5_rst_data", 32'(|blk_data), 32'd0);
        repeat (2) step();
        rst_n     = 1'b1;
        seen_rdy  = 0;
        seen_drop = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) seen_rdy++;
            if (blk_valid) seen_drop++;
            step();
        end
        in_valid = 1'b0;
        check("t5_no_ready", 32'(seen_rdy), 32'd0);
        check("t5_no_valid", 32'(seen_drop), 32'd0);
        do_start(1'b1, 1'b0);
        send_bytes(768, 2, 8'h00, 1'b0);
        check("t5_xfers", 32'(sent), 32'd768);
        check("t5_blk_valid", 32'(blk_valid), 32'd1);
        check("t5_k", 32'(blk_k_eq_6144), 32'd1);
        check_block("t5_block", 768);

        // 6: start alone in HOLD is ignored; start with blk_ready restarts
        start = 1'b1;
        k_sel = 1'b0;
        step();
        start = 1'b0;
        check("t6_ign_valid", 32'(blk_valid), 32'd1);
        check("t6_ign_k", 32'(blk_k_eq_6144), 32'd1);
        compare_blk("t6_ign_block");
        start     = 1'b1;
        k_sel     = 1'b0;
        blk_ready = 1'b1;
        step();
        start     = 1'b0;
        blk_ready = 1'b0;
        check("t6_valid", 32'(blk_valid), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_data_zero", 32'(|blk_data), 32'd0);
        check("t6_k", 32'(blk_k_eq_6144), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_code_block_loader

// File: doc/code_block_loader.md
Name: code_block_loader

Overview:
Upstream stage of the coder interleaver. Accepts a byte stream of one turbo code block (K = 6144 or K = 1056 bits) over a valid/ready handshake and assembles it into a flat 6144-bit register. It then presents that register, plus the K select, as a stable block with a valid/ready handshake. Its block outputs drive the interleaver's cin and K_eq_6144 inputs directly.

Parameters:
K_MAX, 6144, block buffer width in bits (large code block size)
K_SMALL, 1056, small code block size in bits
W, 8, input data width in bits; K_MAX and K_SMALL are multiples of W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
start  input  1  one-cycle pulse that begins a new block
k_sel  input  1  block size select, sampled on start (1 = K_MAX, 0 = K_SMALL)
in_data  input  W  input byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts in_data this cycle
blk_data  output  K_MAX  assembled block; feeds interleaver cin
blk_k_eq_6144  output  1  latched k_sel; feeds interleaver K_eq_6144
blk_valid  output  1  blk_data holds a complete block
blk_ready  input  1  downstream has consumed the block
busy  output  1  high in FILL or HOLD

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, byte counter = 0.
  - blk_data = 0, blk_k_eq_6144 = 0, blk_valid = 0, in_ready = 0, busy = 0.
- FSM states: IDLE, FILL, HOLD. All outputs are registered or decoded from state only; there is no combinational path from an input to an output.
- IDLE:
  - in_ready = 0.
  - On start: latch k_sel into blk_k_eq_6144, clear counter, clear all of blk_data to 0, go to FILL.
- FILL:
  - in_ready = 1.
  - A transfer occurs when in_valid and in_ready are both high. It writes in_data into blk_data[W*cnt +: W]. in_data[0] lands at the lower bit index, so byte 0 bit 0 is blk_data[0].
  - cnt is 10 bits. Target byte count is K_MAX/W = 768 or K_SMALL/W = 132.
  - The transfer that writes byte (target-1) moves the FSM to HOLD. That same cycle cnt wraps to 0.
  - When K = K_SMALL, blk_data[K_MAX-1:K_SMALL] stays 0.
  - in_valid low: no write, counter holds. Gaps of any length are allowed.
- HOLD:
  - blk_valid = 1, in_ready = 0. blk_data and blk_k_eq_6144 are frozen.
  - On blk_ready: blk_valid drops next cycle, go to IDLE.
- Latency: last byte accepted at edge N, so blk_valid = 1 from edge N. At full rate a block takes 768 (or 132) cycles after the start cycle.
- Simultaneous and boundary events:
  - start in FILL: abort and restart. Relatch k_sel, clear counter and blk_data, stay in FILL. An in_valid on that same cycle is discarded.
  - start in HOLD without blk_ready: ignored.
  - start together with blk_ready in HOLD: block is consumed and the FSM goes straight to FILL with the new k_sel and a cleared buffer.
  - blk_ready in IDLE or FILL: ignored.
  - in_valid in IDLE or HOLD: not accepted (in_ready = 0), no state change.
  - rst_n asserted mid-FILL or mid-HOLD: immediate return to reset values. The partial block is lost and no blk_valid is produced.
- k_sel changes outside a start cycle have no effect.

Decomposition:
- Shared coder package holds:
  - constants K_MAX = 6144, K_SMALL = 1056, W = 8, BYTES_MAX = 768, BYTES_SMALL = 132;
  - FSM state typedef {IDLE, FILL, HOLD}, also used by the future downstream serializer.
- No sub-module is needed. The byte-write decode is a single indexed part-select inside the block.

Test Plan:
1. Reset, then start with k_sel=0, then 132 consecutive bytes with in_data = index mod 256.
   - blk_valid rises the cycle after byte 131 is accepted.
   - blk_data[7:0]=0x00, blk_data[1055:1048]=0x83, blk_data[6143:1056]=0, blk_k_eq_6144=0.
2. start with k_sel=1; 768 bytes of 0xA5 with in_valid low every third cycle.
   - Exactly 768 transfers occur; blk_data is all 0xA5 in every byte; blk_k_eq_6144=1.
3. Complete block with blk_ready held low for 50 cycles.
   - blk_valid stays 1, blk_data is unchanged, in_ready=0, extra in_valid is ignored.
   - blk_ready pulse: blk_valid=0 next cycle, then IDLE.
4. start with k_sel=1, 100 bytes of 0xFF, then start with k_sel=0, then 132 bytes of 0x01.
   - blk_k_eq_6144=0, every byte of blk_data[1055:0] = 0x01, blk_data[6143:1056]=0.
5. Deassert rst_n mid-FILL at byte 400.
   - All outputs return to 0 immediately; no blk_valid follows.
   - A fresh start then fills correctly.
6. In HOLD, assert start (k_sel=0) and blk_ready in the same cycle.
   - Next cycle: blk_valid=0, in_ready=1, blk_data all 0, blk_k_eq_6144=0.
